axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Round-robin scheduler that shares the single AXI read master port (AR and R channels) of the PageRank accelerator among NREQ internal fetch units (vertex, in-edge and rank readers). It grants one requester at a time, issues its burst on the AR channel, then steers the returning R beats back to that requester only. Write channels are out of scope. The block sits between the fetch units and the `axi_emu` or shell memory port.

## Interface
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 64, AXI address width
- DATA_W, 512, AXI data width (one 64-byte beat)
- ID_W, 16, AXI ID width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low (clears state when rst==0 at a clk edge)
- req_valid  in  NREQ  per-requester burst request
- req_addr  in  NREQ*ADDR_W  flattened byte addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_len  in  NREQ*8  flattened AXI len (beats-1)
- req_ready  out  NREQ  one-cycle pulse: requester i's AR accepted
- resp_valid  out  NREQ  R beat valid, one-hot to granted requester
- resp_data  out  DATA_W  shared beat data (rdata_m pass-through)
- resp_last  out  1  last beat of burst (rlast_m pass-through)
- resp_ready  in  NREQ  per-requester beat acceptance
- arid_m, araddr_m, arlen_m, arsize_m, arvalid_m  out  ID_W, ADDR_W, 8, 3, 1  AXI AR
- arready_m  in  1
- rid_m, rdata_m, rresp_m, rlast_m, rvalid_m  in  ID_W, DATA_W, 2, 1, 1  AXI R
- rready_m  out  1
- err  out  1  sticky protocol/response error flag

## Operation
- States: IDLE, AR, R. Reset → IDLE, ptr=0, err=0.
- IDLE: if any req_valid, select the first asserted index searching ptr, ptr+1, …, wrapping at NREQ; latch g, addr, and len; go to AR. No request means stay in IDLE.
- AR: arvalid_m=1; araddr_m=latched addr; arlen_m=latched len; arsize_m=3'b110; arid_m=g zero-extended. On arready_m: req_ready[g]=1 (combinational, same cycle), load beat counter=len, go to R.
- R: rready_m=resp_ready[g]; resp_valid[g]=rvalid_m, and every other resp_valid bit is 0. A beat transfers when rvalid_m&&rready_m; the counter decrements per beat. On the beat with rlast_m: ptr ← (g+1) mod NREQ, go to IDLE.
- Requesters hold req_valid/addr/len stable until req_ready. The arbiter samples them only in IDLE at grant.
- Errors set err (cleared only by reset) under three conditions: transferred beat has rresp_m≠0; rid_m≠g; rlast_m arrives with counter≠0 or counter hits 0 without rlast_m. Beats are still forwarded, and the burst always terminates on rlast_m.
- A requester dropping req_valid after grant has no effect. The burst completes.

## Timing
- Reset values: arvalid_m=0, araddr_m=0, arlen_m=0, arid_m=0, arsize_m=0, rready_m=0, req_ready=0, resp_valid=0, resp_last=0, err=0. resp_data mirrors rdata_m.
- Grant latency: req_valid seen in IDLE at edge t gives arvalid_m=1 from t+1.
- arvalid_m holds, with stable fields, until arready_m. A single AR is outstanding at a time.
- R path is combinational pass-through with no added latency. Back-pressure is resp_ready[g]→rready_m.
- One IDLE bubble cycle between consecutive bursts. A full burst takes 1 + AR wait + (len+1) beats minimum.
- Reset asserted mid-burst: state returns to IDLE next edge and outputs take their reset values. The AXI slave shares the same reset.
- rvalid_m in IDLE/AR: rready_m=0, no resp_valid, no error.

## Test plan
- Single request: req 1 valid, addr=160, len=3, arready after 2 cycles → arid_m=1, araddr_m=160, arlen_m=3, arsize_m=6. req_ready[1] pulses once. Exactly 4 beats reach resp_valid[1], resp_last on the 4th, then IDLE.
- Round robin: all 3 requesters valid continuously with len=0 → grant order 0,1,2,0,1,2. Each AR is separated by R completion plus 1 IDLE cycle.
- Back-pressure: resp_ready[0] toggling 1,0,0,1 during a len=7 burst → rready_m follows it exactly, and 8 beats arrive in order with none dropped.
- Error paths: rresp_m=2 on beat 2 → err=1 and stays 1. A separate run with rid_m≠g also sets err, and a run with rlast_m early at beat 1 of len=3 sets err and returns to IDLE.
- Reset mid-burst: rst=0 during beat 2 of len=7 → next cycle all outputs are at reset values and ptr=0. A new request after rst=1 is granted normally.
- Stable AR: arready_m held low 10 cycles while other req_valid toggle → araddr_m, arlen_m and arid_m are unchanged, and no req_ready pulses.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Round-robin scheduler sharing one AXI read master (AR + R channels) among
// NREQ fetch units. One requester is granted at a time: its burst is issued
// on AR, then the returning R beats are steered back to it alone.
//
// Ports
//   clk, rst                   clock, synchronous active-low reset
//   req_valid/addr/len         per-requester burst requests (flattened buses)
//   req_ready                  one-cycle pulse when requester's AR is accepted
//   resp_valid/data/last       R beats returned to the granted requester
//   resp_ready                 per-requester beat acceptance
//   ar*_m                      AXI AR channel towards memory
//   r*_m, rready_m             AXI R channel from memory
//   err                        sticky protocol/response error flag
module axi_rd_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int ID_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*8-1:0]      req_len,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_last,
    input  logic [NREQ-1:0]        resp_ready,
    output logic [ID_W-1:0]        arid_m,
    output logic [ADDR_W-1:0]      araddr_m,
    output logic [7:0]             arlen_m,
    output logic [2:0]             arsize_m,
    output logic                   arvalid_m,
    input  logic                   arready_m,
    input  logic [ID_W-1:0]        rid_m,
    input  logic [DATA_W-1:0]      rdata_m,
    input  logic [1:0]             rresp_m,
    input  logic                   rlast_m,
    input  logic                   rvalid_m,
    output logic                   rready_m,
    output logic                   err
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   g_q, g_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [PTR_W:0]     pick;
    logic [ID_W-1:0]    g_id;
    logic               beat;

    // Returns {found, index} of the first asserted request scanning p, p+1, ...
    // with wrap at NREQ. Scanning downward lets the lowest offset win.
    function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [PTR_W-1:0] p);
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (v[idx]) res = {1'b1, idx[PTR_W-1:0]};
        end
        return res;
    endfunction

    // Beat counter saturates at zero so an overrunning slave cannot wrap it.
    function automatic logic [7:0] sat_dec(input logic [7:0] c);
        return (c == 8'd0) ? 8'd0 : c - 8'd1;
    endfunction

    assign g_id      = ID_W'(g_q);
    assign beat      = rvalid_m && rready_m;
    assign resp_data = rdata_m;
    assign err       = err_q;

    // AR fields are forced to zero outside the address phase so they read as
    // reset values whenever no address is being offered.
    assign arvalid_m = (state_q == S_AR);
    assign araddr_m  = arvalid_m ? addr_q : '0;
    assign arlen_m   = arvalid_m ? len_q : 8'd0;
    assign arsize_m  = arvalid_m ? 3'b110 : 3'b000;
    assign arid_m    = arvalid_m ? g_id : '0;
    assign resp_last = (state_q == S_R) ? rlast_m : 1'b0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_d        = g_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        req_ready  = '0;
        resp_valid = '0;
        rready_m   = 1'b0;
        pick       = rr_pick(req_valid, ptr_q);

        case (state_q)
            S_IDLE: begin
                if (pick[PTR_W]) begin
                    g_d     = pick[PTR_W-1:0];
                    addr_d  = req_addr[pick[PTR_W-1:0]*ADDR_W +: ADDR_W];
                    len_d   = req_len[pick[PTR_W-1:0]*8 +: 8];
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (arready_m) begin
                    req_ready[g_q] = 1'b1;
                    cnt_d          = len_q;
                    state_d        = S_R;
                end
            end
            S_R: begin
                rready_m        = resp_ready[g_q];
                resp_valid[g_q] = rvalid_m;
                if (beat) begin
                    // Last beat is expected exactly when the counter is zero.
                    if ((rresp_m != 2'b00) || (rid_m != g_id) ||
                        (rlast_m != (cnt_q == 8'd0)))
                        err_d = 1'b1;
                    cnt_d = sat_dec(cnt_q);
                    if (rlast_m) begin
                        ptr_d   = (g_q == PTR_W'(NREQ - 1)) ? '0 : g_q + 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage boundary: control state (reset) and latched burst fields (no reset).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        g_q    <= g_d;
        addr_q <= addr_d;
        len_q  <= len_d;
        cnt_q  <= cnt_d;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int ID_W   = 16;

    logic                   clk, rst;
    logic [NREQ-1:0]        req_valid, req_ready, resp_valid, resp_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*8-1:0]      req_len;
    logic [DATA_W-1:0]      resp_data, rdata_m;
    logic                   resp_last;
    logic [ID_W-1:0]        arid_m, rid_m;
    logic [ADDR_W-1:0]      araddr_m;
    logic [7:0]             arlen_m;
    logic [2:0]             arsize_m;
    logic                   arvalid_m, arready_m, rlast_m, rvalid_m, rready_m, err;
    logic [1:0]             rresp_m;

    axi_rd_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last), .resp_ready(resp_ready),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m),
        .rready_m(rready_m), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    function automatic logic [DATA_W-1:0] rand_data(input int tag);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        d[31:0] = 32'(tag);
        return d;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    int          m_owner = -1;   // requester holding the port, -1 if none
    bit          m_ar_done = 0;  // its address has been accepted
    int          m_left = 0;     // beats still expected
    int          m_ptr = 0;
    bit          m_err = 0;
    logic [63:0] m_addr = '0;
    logic [7:0]  m_len = '0;

    task automatic model_step();
        int idx;
        bit found;
        if (!rst) begin
            m_owner = -1; m_ar_done = 0; m_ptr = 0; m_err = 0;
        end else if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && req_valid[idx]) begin
                    found = 1; m_owner = idx; m_ar_done = 0;
                    m_addr = req_addr[idx*ADDR_W +: ADDR_W];
                    m_len  = req_len[idx*8 +: 8];
                end
            end
        end else if (!m_ar_done) begin
            if (arready_m) begin
                m_ar_done = 1;
                m_left = int'(m_len) + 1;
            end
        end else if (rvalid_m && resp_ready[m_owner]) begin
            if (rresp_m != 2'b00) m_err = 1;
            if (rid_m != ID_W'(m_owner)) m_err = 1;
            m_left--;
            if (rlast_m != (m_left == 0)) m_err = 1;
            if (rlast_m) begin
                m_ptr = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare + monitor ----------------
    bit   chk_en = 0;
    int   cyc = 0;
    int   acc_cnt[NREQ], rx_cnt[NREQ], rx_last_at[NREQ];
    int   acc_q[$], acc_t[$];
    logic [7:0] rx_q[$];

    initial forever begin
        logic [NREQ-1:0] e_rq, e_rv;
        bit inar, inr;
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            inar = (m_owner >= 0) && !m_ar_done;
            inr  = (m_owner >= 0) && m_ar_done;
            e_rq = '0; e_rv = '0;
            if (inar && arready_m) e_rq[m_owner] = 1'b1;
            if (inr && rvalid_m) e_rv[m_owner] = 1'b1;
            chk("arvalid", arvalid_m, inar);
            chk("araddr", araddr_m, inar ? m_addr : 64'd0);
            chk("arlen", arlen_m, inar ? m_len : 8'd0);
            chk("arsize", arsize_m, inar ? 3'd6 : 3'd0);
            chk("arid", arid_m, inar ? ID_W'(m_owner) : '0);
            chk("req_ready", req_ready, e_rq);
            chk("rready", rready_m, inr ? resp_ready[m_owner] : 1'b0);
            chk("resp_valid", resp_valid, e_rv);
            chk("resp_last", resp_last, inr ? rlast_m : 1'b0);
            chk("resp_data", resp_data, rdata_m);
            chk("err", err, m_err);
        end
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    acc_cnt[i]++; acc_q.push_back(i); acc_t.push_back(cyc);
                end
                if (resp_valid[i] && resp_ready[i]) begin
                    rx_cnt[i]++;
                    if (resp_last) rx_last_at[i] = rx_cnt[i];
                    if (i == 0) rx_q.push_back(resp_data[7:0]);
                end
            end
        end
    end

    // ---------------- AXI slave emulation ----------------
    int cfg_ar_delay = 0;     // <0: random arready
    int cfg_rv_pct = 100;
    int cfg_err_beat = -1;
    int cfg_early = -1;
    bit cfg_bad_id = 0;
    bit cfg_junk = 0;

    initial begin
        bit n_ar_fire, n_r_fire, n_rst, s_active, s_pend;
        logic [ID_W-1:0] n_arid, s_id;
        logic [7:0] n_arlen;
        int s_len, s_beat, s_ar_cnt;
        arready_m = 0; rvalid_m = 0; rdata_m = '0; rid_m = '0; rresp_m = '0; rlast_m = 0;
        s_active = 0; s_pend = 0; s_ar_cnt = 0; s_id = '0; s_len = 0; s_beat = 0;
        forever begin
            @(negedge clk);
            n_rst = rst;
            n_ar_fire = arvalid_m && arready_m;
            n_r_fire = rvalid_m && rready_m;
            n_arid = arid_m; n_arlen = arlen_m;
            if (arvalid_m && !arready_m) s_ar_cnt++;
            @(posedge clk); #1;
            if (!n_rst) begin
                s_active = 0; s_pend = 0; s_ar_cnt = 0;
                arready_m = 0; rvalid_m = 0; rlast_m = 0;
            end else begin
                if (n_ar_fire) begin
                    s_active = 1; s_id = n_arid; s_len = int'(n_arlen);
                    s_beat = 0; s_ar_cnt = 0; s_pend = 0;
                end
                if (n_r_fire && s_pend) begin
                    s_pend = 0;
                    if (rlast_m) s_active = 0;
                    else s_beat++;
                end
                if (cfg_ar_delay < 0) arready_m = ($urandom % 2) == 1;
                else arready_m = arvalid_m && (s_ar_cnt >= cfg_ar_delay);
                if (s_active) begin
                    if (!s_pend) begin
                        if ($urandom_range(99) < cfg_rv_pct) begin
                            rvalid_m = 1;
                            rdata_m  = rand_data(s_beat);
                            rlast_m  = (s_beat == s_len) || (s_beat == cfg_early);
                            rresp_m  = (s_beat == cfg_err_beat) ? 2'd2 : 2'd0;
                            rid_m    = cfg_bad_id ? (s_id ^ 16'h0005) : s_id;
                            s_pend   = 1;
                        end else begin
                            rvalid_m = 0;
                        end
                    end
                end else begin
                    rvalid_m = cfg_junk && (($urandom % 4) == 0);
                    rdata_m  = rand_data($urandom);
                    rid_m    = ID_W'($urandom);
                    rresp_m  = 2'($urandom);
                    rlast_m  = 1'($urandom);
                end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 0; tick(); tick(); rst = 1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NREQ; i++) begin
            acc_cnt[i] = 0; rx_cnt[i] = 0; rx_last_at[i] = 0;
        end
        acc_q.delete(); acc_t.delete(); rx_q.delete();
    endtask

    task automatic wait_acc(input int who, input int budget);
        bit ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            tick();
            if (acc_cnt[who] > 0) ok = 1;
        end
        chk("grant_within_budget", ok, 1'b1);
    endtask

    task automatic wait_done(input int who, input int budget);
        bit ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            tick();
            if (rx_last_at[who] != 0) ok = 1;
        end
        chk("burst_done_within_budget", ok, 1'b1);
    endtask

    task automatic set_req(input int who, input logic [63:0] a, input logic [7:0] l);
        req_addr[who*ADDR_W +: ADDR_W] = a;
        req_len[who*8 +: 8] = l;
        req_valid[who] = 1'b1;
    endtask

    task automatic run_burst(input int who, input logic [63:0] a, input logic [7:0] l);
        clear_stats();
        set_req(who, a, l);
        wait_acc(who, 100);
        req_valid[who] = 1'b0;
        wait_done(who, 400);
    endtask

    initial begin
        bit pat[4];
        logic [63:0] a2;
        int k, tot;
        bit ok;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        rst = 0; req_valid = '0; req_addr = '0; req_len = '0; resp_ready = '1;
        @(posedge clk); #1;
        chk_en = 1;
        do_reset();

        // reset state
        chk("rst_arvalid", arvalid_m, 1'b0);
        chk("rst_araddr", araddr_m, 64'd0);
        chk("rst_arsize", arsize_m, 3'd0);
        chk("rst_resp_valid", resp_valid, 3'b000);
        chk("rst_err", err, 1'b0);

        // single request
        clear_stats();
        cfg_ar_delay = 2;
        set_req(1, 64'd160, 8'd3);
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            tick();
            if (arvalid_m) ok = 1;
        end
        chk("t1_arvalid", arvalid_m, 1'b1);
        chk("t1_arid", arid_m, 16'd1);
        chk("t1_araddr", araddr_m, 64'd160);
        chk("t1_arlen", arlen_m, 8'd3);
        chk("t1_arsize", arsize_m, 3'd6);
        wait_acc(1, 20);
        req_valid[1] = 1'b0;
        wait_done(1, 50);
        tick(); tick();
        chk("t1_ready_pulses", acc_cnt[1], 1);
        chk("t1_beats", rx_cnt[1], 4);
        chk("t1_last_on_4th", rx_last_at[1], 4);
        chk("t1_idle_arvalid", arvalid_m, 1'b0);

        // round robin with len=0
        do_reset();
        clear_stats();
        cfg_ar_delay = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 64'(i * 64 + 4096), 8'd0);
        for (int c = 0; c < 100 && acc_q.size() < 6; c++) tick();
        req_valid = '0;
        chk("rr_count", acc_q.size() >= 6, 1'b1);
        if (acc_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("rr_order", acc_q[i], i % 3);
            for (int i = 1; i < 6; i++) chk("rr_gap", acc_t[i] - acc_t[i-1], 3);
        end
        for (int c = 0; c < 10; c++) tick();

        // back-pressure during a len=7 burst
        clear_stats();
        set_req(0, 64'h0000_1234_0000_0040, 8'd7);
        wait_acc(0, 50);
        req_valid[0] = 1'b0;
        k = 0;
        ok = 0;
        for (int c = 0; c < 80 && !ok; c++) begin
            resp_ready[0] = pat[k % 4];
            k++;
            tick();
            if (rx_last_at[0] != 0) ok = 1;
        end
        resp_ready = '1;
        chk("bp_done", ok, 1'b1);
        chk("bp_beats", rx_cnt[0], 8);
        chk("bp_qsize", rx_q.size(), 8);
        for (int i = 0; i < rx_q.size() && i < 8; i++) chk("bp_order", rx_q[i], 8'(i));

        // AR held while other requests toggle
        clear_stats();
        cfg_ar_delay = 1000;
        a2 = {$urandom, $urandom};
        set_req(2, a2, 8'd5);
        for (int c = 0; c < 10 && !arvalid_m; c++) tick();
        for (int c = 0; c < 10; c++) begin
            req_valid[0] = 1'($urandom);
            req_valid[1] = 1'($urandom);
            req_addr[ADDR_W-1:0] = {$urandom, $urandom};
            tick();
            chk("stable_araddr", araddr_m, a2);
            chk("stable_arlen", arlen_m, 8'd5);
            chk("stable_arid", arid_m, 16'd2);
        end
        tot = acc_cnt[0] + acc_cnt[1] + acc_cnt[2];
        chk("stable_no_ready", tot, 0);
        req_valid[1:0] = 2'b00;
        cfg_ar_delay = 0;
        wait_acc(2, 20);
        req_valid[2] = 1'b0;
        wait_done(2, 50);

        // error: rresp on beat 2, stays sticky
        do_reset();
        chk("errA_clear", err, 1'b0);
        cfg_err_beat = 2;
        run_burst(2, 64'h200, 8'd3);
        cfg_err_beat = -1;
        tick();
        chk("errA_set", err, 1'b1);
        run_burst(0, 64'h300, 8'd1);
        tick();
        chk("errA_sticky", err, 1'b1);

        // error: wrong rid
        do_reset();
        chk("errB_clear", err, 1'b0);
        cfg_bad_id = 1;
        run_burst(0, 64'h400, 8'd1);
        cfg_bad_id = 0;
        tick();
        chk("errB_set", err, 1'b1);

        // error: early rlast at beat 1 of len=3
        do_reset();
        cfg_early = 1;
        run_burst(1, 64'h500, 8'd3);
        cfg_early = -1;
        tick();
        chk("errC_set", err, 1'b1);
        chk("errC_beats", rx_cnt[1], 2);
        chk("errC_idle", arvalid_m | rready_m, 1'b0);
        run_burst(0, 64'h600, 8'd0);

        // reset in the middle of a burst
        do_reset();
        clear_stats();
        set_req(1, 64'h700, 8'd7);
        wait_acc(1, 20);
        req_valid[1] = 1'b0;
        for (int c = 0; c < 50 && rx_cnt[1] < 2; c++) tick();
        chk("mid_beats_before_rst", rx_cnt[1], 2);
        rst = 0;
        tick();
        chk("mid_rst_arvalid", arvalid_m, 1'b0);
        chk("mid_rst_rready", rready_m, 1'b0);
        chk("mid_rst_resp_valid", resp_valid, 3'b000);
        chk("mid_rst_resp_last", resp_last, 1'b0);
        chk("mid_rst_arid", arid_m, 16'd0);
        rst = 1;
        clear_stats();
        set_req(0, 64'h800, 8'd0);
        set_req(2, 64'h900, 8'd0);
        for (int c = 0; c < 20 && acc_q.size() < 1; c++) tick();
        req_valid = '0;
        chk("mid_regrant_ptr0", acc_q.size() > 0 ? acc_q[0] : -1, 0);
        for (int c = 0; c < 20; c++) tick();

        // randomized traffic
        cfg_ar_delay = -1; cfg_rv_pct = 60; cfg_junk = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && acc_cnt[i] > 0) begin
                    req_valid[i] = 1'b0;
                    acc_cnt[i] = 0;
                end else if (!req_valid[i] && ($urandom % 8) == 0) begin
                    set_req(i, {$urandom, $urandom}, 8'($urandom_range(3)));
                end else if (req_valid[i] && ($urandom % 64) == 0) begin
                    req_valid[i] = 1'b0;
                end
                resp_ready[i] = ($urandom % 4) != 0;
            end
            rst = ($urandom % 500) != 0;
            tick();
        end
        rst = 1; req_valid = '0; resp_ready = '1; cfg_ar_delay = 0; cfg_rv_pct = 100;
        for (int c = 0; c < 60; c++) tick();
        chk("drain_idle", arvalid_m | rready_m, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
